decode_wide: RTL and testbench
==============================

# decode_wide

Parametrised multi-lane decode stage between fetch (FE1) and rename (RN0). Decodes up to NFE fetched instructions per cycle into t_uinstr through f_decode_rv_instr, buffers them in an in-order circular uop queue of DEPTH entries, and hands up to NRN uops per cycle to rename. It generalises the single-lane decode with independent fetch and rename widths and a credit-count rename handshake. It also keeps the existing EBREAK fence and nuke flush.

## Interface
- NFE, 2: fetch/decode lanes per cycle; 1..4.
- NRN, 2: rename lanes per cycle; 1..4.
- DEPTH, 8: uop queue entries; power of two, DEPTH >= max(NFE, NRN).
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- nuke_rb1  in  t_nuke_pkt  only .valid is used; flushes the block.
- valid_fe1  in  NFE  per-lane valid. Lanes are contiguous from lane 0 (precondition, asserted).
- instr_fe1  in  NFE x t_instr_pkt  per-lane instruction packet (.instr, .pc, SIMID).
- decode_ready_de0  out  1  the queue can accept a full NFE bundle this cycle.
- rename_cnt_rn0  in  $clog2(NRN+1)  number of uops rename accepts this cycle; 0..NRN.
- valid_de1  out  NRN  per-lane pop valid, contiguous from lane 0.
- uinstr_de1  out  NRN x t_uinstr  popped uops, oldest in lane 0.
- occ_de1  out  $clog2(DEPTH+1)  registered queue occupancy.
- ebreak_blk_de1  out  1  registered EBREAK fence state.

## Operation
- State:
  - storage[DEPTH]
  - wr_ptr, rd_ptr: $clog2(DEPTH) bits each; wrap modulo DEPTH.
  - count: $clog2(DEPTH+1) bits.
  - ebreak_blk: 1 bit.
- Decode (DE0, combinational):
  - uop[i] = f_decode_rv_instr(instr_fe1[i].instr).
  - .pc and SIMID are overridden from instr_fe1[i].
- decode_ready_de0 = (DEPTH - count) >= NFE.
  - Uses registered count only.
  - Same-cycle pops are not credited.
- Push enable: push_en = decode_ready_de0 & ~ebreak_blk & ~nuke_rb1.valid.
  - If push_en = 0, all FE lanes are dropped; upstream must hold them.
- Lanes pushed:
  - Lane i is pushed if push_en & valid_fe1[i] and no lane j < i is a valid U_EBREAK.
  - The EBREAK lane itself is pushed; younger lanes are discarded.
  - Pushed lanes are written in lane order at wr_ptr, wr_ptr+1, ... (mod DEPTH).
  - n_push = number of lanes pushed.
- Pops:
  - n_pop = 0 when nuke_rb1.valid.
  - Otherwise n_pop = min(count, rename_cnt_rn0).
  - For lane k < n_pop: valid_de1[k] = 1 and uinstr_de1[k] = storage[rd_ptr+k].
  - For lanes k >= n_pop: valid_de1[k] = 0; uinstr_de1[k] shows storage[rd_ptr+k], a don't-care.
- Update on a normal cycle:
  - count += n_push - n_pop.
  - wr_ptr += n_push; rd_ptr += n_pop.
- ebreak_blk:
  - Set when any EBREAK lane is pushed.
  - Cleared by nuke_rb1.valid; nuke has priority over set.
  - While set, no pushes occur; the queue still drains to rename.
- Nuke: with nuke_rb1.valid high, at the next edge count = 0, wr_ptr = rd_ptr = 0, ebreak_blk = 0. No pop and no push happen in the nuke cycle.
- Assertions (ASSERT):
  - count <= DEPTH.
  - Push never issued when ~decode_ready_de0.
  - valid_fe1 contiguous.
  - rename_cnt_rn0 <= NRN.

## Timing
- Async reset values (registers):
  - count = 0, wr_ptr = 0, rd_ptr = 0, ebreak_blk = 0.
  - Storage is not reset.
- Output values while reset is asserted:
  - decode_ready_de0 = 1 (DEPTH >= NFE).
  - valid_de1 = 0, occ_de1 = 0, ebreak_blk_de1 = 0.
- Latency: a uop pushed in cycle N is poppable in cycle N+1 at the earliest. There is no bypass from push to pop in the same cycle.
- Full queue (count > DEPTH-NFE): decode_ready_de0 = 0. The bundle is held upstream until pops free NFE entries, visible the cycle after the pop.
- Empty queue (count = 0): valid_de1 = 0 regardless of rename_cnt_rn0.
- Simultaneous push and pop: both apply, and the net count change is n_push - n_pop. This holds at wrap-around as well.
- Reset asserted mid-operation: the state clears immediately, asynchronously. Queued uops are lost.
- Nuke together with a valid FE bundle: the bundle is dropped. The first push possible after the nuke is in the next cycle.

## Test plan
- Reset, then push 2 ADDs (NFE=2, NRN=2) with rename_cnt_rn0=2:
  - Cycle+1: valid_de1=2'b11 carrying the PCs in order.
  - occ_de1 returns to 0.
- rename_cnt_rn0=0 while pushing 2 per cycle (DEPTH=8):
  - After 4 cycles occ_de1=8 and decode_ready_de0=0.
  - Next, rename_cnt_rn0=1 for 2 cycles: decode_ready_de0 returns to 1 once occ_de1=6.
- Bundle with lane0=EBREAK, lane1=ADD:
  - Only the EBREAK is queued; ebreak_blk_de1=1.
  - Later bundles are not pushed.
  - nuke_rb1.valid clears ebreak_blk_de1 and occ_de1 to 0.
- Nuke pulse while occ_de1=5 and rename_cnt_rn0=2:
  - valid_de1=0 in the nuke cycle.
  - Next cycle occ_de1=0; no stale uops appear afterwards.
- Wrap-around: alternate push 2 / pop 1 for 20 cycles and check FIFO order by SIMID across pointer wrap. occ_de1 never exceeds 8.
- NFE=1, NRN=2, single instruction per cycle with rename_cnt_rn0=2:
  - valid_de1 never has lane 1 without lane 0.
  - Throughput is 1 uop per cycle after the first-cycle latency.

Source files
------------

// File: rtl/decode_wide.sv
// Multi-lane RV decode into an in-order circular uop queue feeding rename, with EBREAK fence and nuke flush.
// Push-to-pop latency 1 cycle; fetch is held via decode_ready_de0 (registered count only), rename pulls by credit count.
package decode_wide_pkg;

    typedef enum logic [2:0] {
        U_ILLEGAL,
        U_ADD,
        U_SUB,
        U_ADDI,
        U_LUI,
        U_ECALL,
        U_EBREAK
    } t_uop;

    typedef struct packed {
        logic valid;
    } t_nuke_pkt;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [15:0] simid;
    } t_instr_pkt;

    typedef struct packed {
        t_uop        op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [15:0] simid;
    } t_uinstr;

    function automatic t_uinstr f_decode_rv_instr(input logic [31:0] instr);
        t_uinstr u;
        u     = '0;
        u.op  = U_ILLEGAL;
        u.rd  = instr[11:7];
        u.rs1 = instr[19:15];
        u.rs2 = instr[24:20];
        case (instr[6:0])
            7'b0110011: begin
                if (instr[14:12] == 3'b000 && instr[31:25] == 7'b0000000) u.op = U_ADD;
                if (instr[14:12] == 3'b000 && instr[31:25] == 7'b0100000) u.op = U_SUB;
            end
            7'b0010011: begin
                if (instr[14:12] == 3'b000) begin
                    u.op  = U_ADDI;
                    u.imm = {{20{instr[31]}}, instr[31:20]};
                end
            end
            7'b0110111: begin
                u.op  = U_LUI;
                u.imm = {instr[31:12], 12'h000};
            end
            7'b1110011: begin
                if (instr == 32'h0000_0073) u.op = U_ECALL;
                if (instr == 32'h0010_0073) u.op = U_EBREAK;
            end
            default: ;
        endcase
        return u;
    endfunction

endpackage

module decode_wide
    import decode_wide_pkg::*;
#(
    parameter int NFE   = 2,
    parameter int NRN   = 2,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  t_nuke_pkt                      nuke_rb1,
    input  logic [NFE-1:0]                 valid_fe1,
    input  t_instr_pkt [NFE-1:0]           instr_fe1,
    output logic                           decode_ready_de0,
    input  logic [$clog2(NRN+1)-1:0]       rename_cnt_rn0,
    output logic [NRN-1:0]                 valid_de1,
    output t_uinstr [NRN-1:0]              uinstr_de1,
    output logic [$clog2(DEPTH+1)-1:0]     occ_de1,
    output logic                           ebreak_blk_de1
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW:0] NFE_C   = NFE[CW:0];
    localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

    t_uinstr         storage_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ebreak_blk_q, ebreak_blk_d;

    t_uinstr         uop [NFE];
    logic [NFE-1:0]  push_lane;
    logic [CW-1:0]   n_push, n_pop, rcnt;
    logic            push_en, ebreak_push, blocked;

    assign decode_ready_de0 = ({1'b0, count_q} + NFE_C) <= DEPTH_C;
    assign push_en          = decode_ready_de0 & ~ebreak_blk_q & ~nuke_rb1.valid;

    always_comb begin
        for (int i = 0; i < NFE; i++) begin
            uop[i]       = f_decode_rv_instr(instr_fe1[i].instr);
            uop[i].pc    = instr_fe1[i].pc;
            uop[i].simid = instr_fe1[i].simid;
        end
    end

    // A valid EBREAK in an older lane suppresses every younger lane, pushed or not.
    always_comb begin
        push_lane   = '0;
        n_push      = '0;
        ebreak_push = 1'b0;
        blocked     = 1'b0;
        for (int i = 0; i < NFE; i++) begin
            push_lane[i] = push_en & valid_fe1[i] & ~blocked;
            if (push_lane[i]) begin
                n_push = n_push + CW'(1);
                if (uop[i].op == U_EBREAK) ebreak_push = 1'b1;
            end
            if (valid_fe1[i] && uop[i].op == U_EBREAK) blocked = 1'b1;
        end
    end

    always_comb begin
        rcnt = CW'(rename_cnt_rn0);
        if (nuke_rb1.valid) n_pop = '0;
        else                n_pop = (count_q < rcnt) ? count_q : rcnt;
        for (int k = 0; k < NRN; k++) begin
            valid_de1[k]  = CW'(k) < n_pop;
            uinstr_de1[k] = storage_q[rd_ptr_q + PW'(k)];
        end
    end

    always_comb begin
        count_d      = count_q + n_push - n_pop;
        wr_ptr_d     = wr_ptr_q + PW'(n_push);
        rd_ptr_d     = rd_ptr_q + PW'(n_pop);
        ebreak_blk_d = ebreak_blk_q | ebreak_push;
        if (nuke_rb1.valid) begin
            count_d      = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            ebreak_blk_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ebreak_blk_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ebreak_blk_q <= ebreak_blk_d;
        end
    end

    // Pushed lanes are contiguous from lane 0, so lane i lands at wr_ptr+i.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NFE; i++) begin
            if (push_lane[i]) storage_q[wr_ptr_q + PW'(i)] <= uop[i];
        end
    end

    assign occ_de1        = count_q;
    assign ebreak_blk_de1 = ebreak_blk_q;

    always @(posedge clk) begin
        if (!reset) begin
            assert ({1'b0, count_q} <= DEPTH_C);
            assert (n_push == '0 || decode_ready_de0);
            assert ((valid_fe1 & (valid_fe1 + NFE'(1))) == '0);
            assert (int'(rename_cnt_rn0) <= NRN);
        end
    end

endmodule

// File: tb/tb_decode_wide.sv
// Directed bench for decode_wide: a 2-wide instance for queue/fence/nuke/wrap behaviour and a 1-wide instance for throughput.
module tb_decode_wide;
    import decode_wide_pkg::*;

    localparam logic [31:0] ADD  = 32'h0031_00B3;
    localparam logic [31:0] EBRK = 32'h0010_0073;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    t_nuke_pkt        nuke0;
    logic [1:0]       vfe0;
    t_instr_pkt [1:0] ife0;
    logic             rdy0;
    logic [1:0]       rcnt0;
    logic [1:0]       vde0;
    t_uinstr [1:0]    ude0;
    logic [3:0]       occ0;
    logic             ebk0;

    t_nuke_pkt        nuke1;
    logic [0:0]       vfe1;
    t_instr_pkt [0:0] ife1;
    logic             rdy1;
    logic [1:0]       rcnt1;
    logic [1:0]       vde1;
    t_uinstr [1:0]    ude1;
    logic [3:0]       occ1;
    logic             ebk1;

    int errors = 0;
    int checks = 0;

    decode_wide #(.NFE(2), .NRN(2), .DEPTH(8)) u_dut0 (
        .clk(clk), .reset(reset), .nuke_rb1(nuke0), .valid_fe1(vfe0), .instr_fe1(ife0),
        .decode_ready_de0(rdy0), .rename_cnt_rn0(rcnt0), .valid_de1(vde0), .uinstr_de1(ude0),
        .occ_de1(occ0), .ebreak_blk_de1(ebk0)
    );

    decode_wide #(.NFE(1), .NRN(2), .DEPTH(8)) u_dut1 (
        .clk(clk), .reset(reset), .nuke_rb1(nuke1), .valid_fe1(vfe1), .instr_fe1(ife1),
        .decode_ready_de0(rdy1), .rename_cnt_rn0(rcnt1), .valid_de1(vde1), .uinstr_de1(ude1),
        .occ_de1(occ1), .ebreak_blk_de1(ebk1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [15:0] sid, input logic [1:0] rc, input logic nk);
        vfe0           = v;
        ife0[0].instr  = i0;
        ife0[0].simid  = sid;
        ife0[0].pc     = 32'h1000 + {14'h0, sid, 2'b00};
        ife0[1].instr  = i1;
        ife0[1].simid  = sid + 16'd1;
        ife0[1].pc     = 32'h1000 + {14'h0, sid + 16'd1, 2'b00};
        rcnt0          = rc;
        nuke0.valid    = nk;
        #2;
    endtask

    int   q[$];
    int   occ_m;
    int   nsid;

    initial begin
        nuke1.valid = 1'b0;
        vfe1 = '0;
        ife1 = '0;
        rcnt1 = '0;

        // Reset state
        drv(2'b00, ADD, ADD, 16'd0, 2'd2, 1'b0);
        chk("rst_ready", rdy0, 1);
        chk("rst_valid", vde0, 0);
        chk("rst_occ", occ0, 0);
        chk("rst_ebreak", ebk0, 0);
        cyc();
        reset = 1'b0;

        // Push two ADDs, pop them next cycle
        cyc(); drv(2'b11, ADD, ADD, 16'd1, 2'd2, 1'b0);
        chk("push_ready", rdy0, 1);
        chk("push_no_bypass", vde0, 2'b00);
        cyc(); drv(2'b00, ADD, ADD, 16'd0, 2'd2, 1'b0);
        chk("pop_valid", vde0, 2'b11);
        chk("pop_pc0", ude0[0].pc, 32'h1004);
        chk("pop_pc1", ude0[1].pc, 32'h1008);
        chk("pop_op", ude0[0].op, U_ADD);
        chk("pop_occ", occ0, 2);
        cyc(); drv(2'b00, ADD, ADD, 16'd0, 2'd2, 1'b0);
        chk("drain_occ", occ0, 0);
        chk("empty_valid", vde0, 2'b00);

        // Fill to full with rename stalled, then trickle out
        for (int c = 0; c < 4; c++) begin
            cyc(); drv(2'b11, ADD, ADD, 16'(10 + 2*c), 2'd0, 1'b0);
        end
        cyc(); drv(2'b11, ADD, ADD, 16'd18, 2'd1, 1'b0);
        chk("full_occ", occ0, 8);
        chk("full_ready", rdy0, 0);
        chk("full_pop_valid", vde0, 2'b01);
        chk("full_pop_sid", ude0[0].simid, 10);
        cyc(); drv(2'b11, ADD, ADD, 16'd18, 2'd1, 1'b0);
        chk("occ7", occ0, 7);
        chk("occ7_ready", rdy0, 0);
        chk("occ7_sid", ude0[0].simid, 11);
        cyc(); drv(2'b11, ADD, ADD, 16'd18, 2'd0, 1'b0);
        chk("occ6", occ0, 6);
        chk("occ6_ready", rdy0, 1);
        for (int c = 0; c < 4; c++) begin
            cyc(); drv(2'b00, ADD, ADD, 16'd0, 2'd2, 1'b0);
            chk("drain_valid", vde0, 2'b11);
            chk("drain_sid0", ude0[0].simid, 32'(12 + 2*c));
            chk("drain_sid1", ude0[1].simid, 32'(13 + 2*c));
        end
        cyc(); drv(2'b00, ADD, ADD, 16'd0, 2'd0, 1'b0);
        chk("drain_done", occ0, 0);

        // EBREAK fence
        cyc(); drv(2'b11, EBRK, ADD, 16'd30, 2'd0, 1'b0);
        chk("ebk_ready", rdy0, 1);
        cyc(); drv(2'b11, ADD, ADD, 16'd32, 2'd0, 1'b0);
        chk("ebk_occ", occ0, 1);
        chk("ebk_set", ebk0, 1);
        cyc(); drv(2'b11, ADD, ADD, 16'd32, 2'd0, 1'b0);
        chk("ebk_blocked_occ", occ0, 1);
        chk("ebk_head_sid", ude0[0].simid, 30);
        chk("ebk_head_op", ude0[0].op, U_EBREAK);
        cyc(); drv(2'b11, ADD, ADD, 16'd32, 2'd1, 1'b1);
        chk("ebk_nuke_valid", vde0, 2'b00);
        cyc(); drv(2'b00, ADD, ADD, 16'd0, 2'd0, 1'b0);
        chk("ebk_nuke_occ", occ0, 0);
        chk("ebk_cleared", ebk0, 0);

        // Nuke with five queued uops and a valid bundle
        cyc(); drv(2'b11, ADD, ADD, 16'd40, 2'd0, 1'b0);
        cyc(); drv(2'b11, ADD, ADD, 16'd42, 2'd0, 1'b0);
        cyc(); drv(2'b01, ADD, ADD, 16'd44, 2'd0, 1'b0);
        cyc(); drv(2'b11, ADD, ADD, 16'd50, 2'd2, 1'b1);
        chk("nuke_occ5", occ0, 5);
        chk("nuke_valid", vde0, 2'b00);
        cyc(); drv(2'b00, ADD, ADD, 16'd0, 2'd2, 1'b0);
        chk("post_nuke_occ", occ0, 0);
        chk("post_nuke_valid", vde0, 2'b00);
        cyc(); drv(2'b11, ADD, ADD, 16'd60, 2'd2, 1'b0);
        chk("no_stale_valid", vde0, 2'b00);
        cyc(); drv(2'b00, ADD, ADD, 16'd0, 2'd2, 1'b0);
        chk("post_nuke_pop", vde0, 2'b11);
        chk("post_nuke_sid0", ude0[0].simid, 60);
        chk("post_nuke_sid1", ude0[1].simid, 61);
        cyc(); drv(2'b00, ADD, ADD, 16'd0, 2'd0, 1'b0);
        chk("pre_wrap_occ", occ0, 0);

        // Push 2 / pop 1 across pointer wrap
        occ_m = 0;
        nsid  = 100;
        for (int c = 0; c < 20; c++) begin
            cyc(); drv(2'b11, ADD, ADD, 16'(nsid), 2'd1, 1'b0);
            chk("wrap_occ", occ0, 32'(occ_m));
            chk("wrap_ready", rdy0, (occ_m <= 6) ? 1 : 0);
            chk("wrap_lane1", vde0[1], 0);
            if (occ_m > 0) begin
                chk("wrap_valid", vde0[0], 1);
                chk("wrap_sid", ude0[0].simid, 32'(q[0]));
                void'(q.pop_front());
            end
            if (occ_m <= 6) begin
                q.push_back(nsid);
                q.push_back(nsid + 1);
                nsid += 2;
            end
            occ_m = q.size();
        end

        // Asynchronous reset mid-operation
        cyc(); drv(2'b00, ADD, ADD, 16'd0, 2'd0, 1'b0);
        chk("pre_reset_occ", occ0, 32'(occ_m));
        reset = 1'b1;
        #1;
        chk("async_rst_occ", occ0, 0);
        chk("async_rst_valid", vde0, 2'b00);
        chk("async_rst_ready", rdy0, 1);
        cyc();
        reset = 1'b0;

        // Single-lane fetch, two-lane rename
        for (int k = 0; k < 6; k++) begin
            cyc();
            vfe1[0]        = (k < 5);
            ife1[0].instr  = ADD;
            ife1[0].simid  = 16'(200 + k);
            ife1[0].pc     = 32'(32'h2000 + 4*k);
            rcnt1          = 2'd2;
            #2;
            chk("n1_valid", vde1, (k == 0) ? 2'b00 : 2'b01);
            chk("n1_occ", occ1, (k == 0) ? 0 : 1);
            if (k > 0) chk("n1_sid", ude1[0].simid, 32'(200 + k - 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
